restore_sign_h: RTL and testbench
=================================

// Module: restore_sign_h
// PURPOSE
//  Converts sign-magnitude samples (magnitude + separate sign bit) back to two's complement.
//  Sits after the magnitude-domain filter stages. It is the inverse of the abs/sign split at filter input.
//  Adds valid/ready flow control, a small output buffer, range saturation and a saturation event counter.
// PARAMETERS
//  WIDTH  16  sample width, both magnitude in and two's-complement out
//  DEPTH  2   output buffer entries (2..8)
//  CNT_W  8   width of saturation event counter
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  datain     in   WIDTH  unsigned magnitude
//  signin     in   1      1 = negative
//  in_valid   in   1      datain/signin valid
//  in_ready   out  1      block can accept a sample
//  dataout    out  WIDTH  two's-complement result (buffer head)
//  sat_out    out  1      dataout was saturated (buffer head)
//  out_valid  out  1      dataout/sat_out valid
//  out_ready  in   1      downstream accepts
//  sat_clr    in   1      clears sat_cnt
//  sat_cnt    out  CNT_W  count of saturated samples, sticks at all-ones
// BEHAVIOUR
//  Reset: one clock; rst_n is asynchronous, active-low. All registers clear on reset.
//   - dataout=0, sat_out=0, out_valid=0, sat_cnt=0, buffer empty.
//   - in_ready=1 one cycle after release. Reset mid-stream discards all buffered samples.
//  Handshake:
//   - Accept when in_valid&&in_ready. Pop when out_valid&&out_ready.
//   - Data is held stable while out_valid&&!out_ready.
//  Latency: a sample accepted in cycle N gives out_valid in N+1 if the buffer was empty.
//  Throughput is 1 sample/cycle when out_ready is held high.
//  in_ready = (count != DEPTH), from the registered count only. There is no combinational path from out_ready.
//  Buffer full: a push and a pop cannot occur in the same cycle. in_ready=0, so the pop is the only event.
//  Buffer empty: out_valid=0. A push and a pop cannot coincide, because the output is registered.
//  Otherwise a simultaneous push and pop leaves count unchanged and both pointers advance.
//  Pointers wrap modulo DEPTH.
//  Conversion is performed at push and stored in the buffer. MAXP=2^(WIDTH-1)-1, MINN=2^(WIDTH-1).
//   - sign=0, mag<=MAXP: out=mag, sat=0
//   - sign=0, mag>MAXP: out=MAXP, sat=1
//   - sign=1, mag==0: out=0, sat=0 (negative zero folds to 0)
//   - sign=1, 0<mag<=MINN: out=(~mag)+1, sat=0 (mag=MINN gives 0x8000 exactly)
//   - sign=1, mag>MINN: out=MINN pattern (0x8000), sat=1
//  sat_cnt:
//   - +1 on each accepted sample with sat=1, saturating at 2^CNT_W-1.
//   - sat_clr alone clears to 0.
//   - sat_clr together with a saturated push sets the count to 1.
//   - The counter counts at accept time, not at pop.
//  There is no state machine beyond the buffer occupancy (EMPTY/PARTIAL/FULL), derived from count.
// STRUCTURE
//  Shared package filter_pkg: WIDTH default, MAXP/MINN constants, and the sat-flag/sample struct {sat, data}.
//  Sub-module restore_sign_fifo: DEPTH x (WIDTH+1) register FIFO with count, wr/rd pointers and a registered head.
//  Top level: combinational converter, FIFO instance and sat counter.
// TESTING
//  1 Reset: hold rst_n=0 with in_valid=1 and datain=5 -> out_valid=0, sat_cnt=0, dataout=0. After release, in_ready=1.
//  2 Basic conversion, out_ready=1:
//     - (5,+) -> 0x0005
//     - (5,-) -> 0xFFFB
//     - (0,-) -> 0x0000
//     - (0x8000,-) -> 0x8000, sat_out=0
//     - Each result appears exactly 1 cycle after accept.
//  3 Saturation:
//     - (0x8000,+) -> 0x7FFF, sat_out=1
//     - (0xFFFF,-) -> 0x8000, sat_out=1
//     - sat_cnt=2 afterwards.
//     - Then pulse sat_clr in the same cycle as a saturated push -> sat_cnt=1.
//  4 Backpressure:
//     - out_ready=0, push 3 samples -> only 2 accepted; in_ready=0 after 2nd accept.
//     - Release out_ready -> outputs appear in order with no loss or duplication.
//     - dataout is stable while stalled.
//  5 Streaming: 1000 random (mag,sign) with random out_ready -> output sequence matches the reference model.
//     Pointer wrap is covered and in_ready never depends combinationally on out_ready.
//  6 Counter ceiling: 260 saturated samples with CNT_W=8 -> sat_cnt sticks at 255.
//     Reset mid-stream with buffer full -> buffer empties; out_valid=0 immediately.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared constants and sample bundle for the magnitude-domain filter chain.
// Default sample width, signed range limits and the {sat, data} pair.
package filter_pkg;

  localparam int FILT_W = 16;

  localparam logic [FILT_W-1:0] MAXP =
    {1'b0, {(FILT_W-1){1'b1}}};
  localparam logic [FILT_W-1:0] MINN =
    {1'b1, {(FILT_W-1){1'b0}}};

  typedef struct packed {
    logic              sat;
    logic [FILT_W-1:0] data;
  } sample_t;

endpackage

// File: rtl/restore_sign_h_if.sv
// Sample stream bundle: sign-magnitude in, two's complement out.
// master drives samples and out_ready, slave is the converter.
interface restore_sign_h_if #(
  parameter int WIDTH = filter_pkg::FILT_W
) ();

  logic [WIDTH-1:0] datain;
  logic             signin;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dataout;
  logic             sat_out;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output datain, signin, in_valid, out_ready,
    input  in_ready, dataout, sat_out, out_valid
  );

  modport slave (
    input  datain, signin, in_valid, out_ready,
    output in_ready, dataout, sat_out, out_valid
  );

endinterface

// File: rtl/restore_sign_fifo.sv
// Small register FIFO with a registered head word.
// in_ready comes from a register, so it never sees out_ready.
module restore_sign_fifo #(
  parameter int DW    = 17,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  output logic [DW-1:0] o_rdata,
  output logic          o_valid,
  output logic          o_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_head;
  logic          r_ready;

  logic [PW-1:0] w_wr_nxt;
  logic [PW-1:0] w_rd_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_push & r_ready;
  assign w_pop  = i_pop & (r_cnt != '0);

  assign w_wr_nxt =
    (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
  assign w_rd_nxt =
    (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;

  // next occupancy from push/pop combination
  always_comb begin
    w_cnt_nxt = r_cnt;
    unique case (1'b1)
      (w_push & ~w_pop): w_cnt_nxt = r_cnt + 1'b1;
      (~w_push & w_pop): w_cnt_nxt = r_cnt - 1'b1;
      default:           w_cnt_nxt = r_cnt;
    endcase
  end

  // pointers, occupancy and registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      if (w_push) r_wr <= w_wr_nxt;
      if (w_pop)  r_rd <= w_rd_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_cnt_nxt != CW'(DEPTH));
    end
  end

  // storage write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr] <= i_wdata;
    end
  end

  // head word: bypass on push to empty or to a draining single entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
    end else if (w_push && r_cnt == '0) begin
      r_head <= i_wdata;
    end else if (w_pop) begin
      if (r_cnt == CW'(1)) begin
        if (w_push) r_head <= i_wdata;
      end else begin
        r_head <= r_mem[w_rd_nxt];
      end
    end
  end

  assign o_rdata = r_head;
  assign o_valid = (r_cnt != '0);
  assign o_ready = r_ready;

endmodule

// File: rtl/restore_sign_h.sv
// Sign-magnitude to two's complement with saturation,
// output buffering and a sticky saturation event counter.
module restore_sign_h
  import filter_pkg::*;
#(
  parameter int WIDTH = FILT_W,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  restore_sign_h_if.slave  bus,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_cnt
);

  typedef struct packed {
    logic             sat;
    logic [WIDTH-1:0] data;
  } samp_t;

  localparam logic [WIDTH-1:0] L_MAXP =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] L_MINN =
    {1'b1, {(WIDTH-1){1'b0}}};

  samp_t            w_conv;
  samp_t            w_head;
  logic             w_big_p;
  logic             w_big_n;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_acc;
  logic             w_sat_acc;
  logic [CNT_W-1:0] r_cnt;

  assign w_big_p = bus.datain[WIDTH-1];
  assign w_big_n = (bus.datain > L_MINN);

  // convert at push; negative zero folds through ~0+1
  always_comb begin
    w_conv = '0;
    unique case (1'b1)
      (~bus.signin & ~w_big_p): begin
        w_conv.data = bus.datain;
      end
      (~bus.signin & w_big_p): begin
        w_conv.data = L_MAXP;
        w_conv.sat  = 1'b1;
      end
      (bus.signin & ~w_big_n): begin
        w_conv.data = (~bus.datain) + WIDTH'(1);
      end
      (bus.signin & w_big_n): begin
        w_conv.data = L_MINN;
        w_conv.sat  = 1'b1;
      end
      default: w_conv = '0;
    endcase
  end

  restore_sign_fifo #(
    .DW    (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (bus.in_valid),
    .i_wdata (w_conv),
    .i_pop   (bus.out_ready),
    .o_rdata (w_head),
    .o_valid (w_out_valid),
    .o_ready (w_in_ready)
  );

  assign w_acc     = bus.in_valid & w_in_ready;
  assign w_sat_acc = w_acc & w_conv.sat;

  // saturation events counted at accept, sticky at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (sat_clr) begin
      r_cnt <= {{(CNT_W-1){1'b0}}, w_sat_acc};
    end else if (w_sat_acc && r_cnt != '1) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.dataout   = w_head.data;
  assign bus.sat_out   = w_head.sat;
  assign sat_cnt       = r_cnt;

endmodule

// File: tb/tb_restore_sign_h.sv
// Bench for restore_sign_h: queue model plus directed literals.
// Model checked at every falling edge.
module tb_restore_sign_h;

  localparam int DEPTH = 2;

  logic       clk;
  logic       rst_n;
  logic       sat_clr;
  logic [7:0] sat_cnt;

  restore_sign_h_if #(.WIDTH(16)) bus ();

  restore_sign_h #(
    .WIDTH (16),
    .DEPTH (DEPTH),
    .CNT_W (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .sat_clr (sat_clr),
    .sat_cnt (sat_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [16:0] q[$];
  int          mcnt;
  bit          armed;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] conv(input int mag,
                                       input bit s);
    int v;
    bit sat;
    sat = 0;
    if (!s) begin
      if (mag > 32767) begin v = 32767; sat = 1; end
      else v = mag;
    end else begin
      if (mag > 32768) begin v = -32768; sat = 1; end
      else v = -mag;
    end
    return {sat, 16'(v)};
  endfunction

  // reference model: accept/pop decided from model state
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      mcnt  = 0;
      armed = 0;
    end else begin
      bit          acc;
      bit          pop;
      logic [16:0] e;
      e   = '0;
      acc = bus.in_valid && armed && q.size() < DEPTH;
      pop = q.size() != 0 && bus.out_ready;
      if (pop) void'(q.pop_front());
      if (acc) begin
        e = conv(int'(bus.datain), bus.signin);
        q.push_back(e);
      end
      if (sat_clr) mcnt = (acc && e[16]) ? 1 : 0;
      else if (acc && e[16] && mcnt < 255) mcnt++;
      armed = 1;
    end
  end

  // compare process
  always @(negedge clk) begin
    chk("out_valid", bus.out_valid, q.size() != 0);
    if (q.size() != 0)
      chk("head", {bus.sat_out, bus.dataout}, q[0]);
    chk("in_ready", bus.in_ready,
        armed && q.size() < DEPTH);
    chk("sat_cnt", sat_cnt, mcnt);
  end

  task automatic send(input logic [15:0] m, input logic s,
                      input logic [15:0] ed, input logic es,
                      input string nm);
    @(negedge clk);
    bus.datain   = m;
    bus.signin   = s;
    bus.in_valid = 1;
    @(negedge clk);
    bus.in_valid = 0;
    chk({nm, "_valid"}, bus.out_valid, 1);
    chk({nm, "_data"}, bus.dataout, ed);
    chk({nm, "_sat"}, bus.sat_out, es);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v[3];
    int          acc;
    int          n;
    int          guard;

    rst_n         = 0;
    sat_clr       = 0;
    bus.in_valid  = 1;
    bus.datain    = 16'd5;
    bus.signin    = 0;
    bus.out_ready = 1;

    // 1 reset
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_cnt", sat_cnt, 0);
    chk("rst_data", bus.dataout, 0);
    rst_n        = 1;
    bus.in_valid = 0;
    @(negedge clk);
    chk("rel_ready", bus.in_ready, 1);

    // 2 conversion
    send(16'd5,    0, 16'h0005, 0, "p5");
    send(16'd5,    1, 16'hFFFB, 0, "n5");
    send(16'd0,    1, 16'h0000, 0, "n0");
    send(16'h8000, 1, 16'h8000, 0, "nmin");

    // 3 saturation
    send(16'h8000, 0, 16'h7FFF, 1, "psat");
    send(16'hFFFF, 1, 16'h8000, 1, "nsat");
    chk("cnt2", sat_cnt, 2);
    @(negedge clk);
    sat_clr      = 1;
    bus.in_valid = 1;
    bus.datain   = 16'h8000;
    bus.signin   = 0;
    @(negedge clk);
    sat_clr      = 0;
    bus.in_valid = 0;
    chk("clr_push", sat_cnt, 1);

    // 4 backpressure
    @(negedge clk);
    bus.out_ready = 0;
    v[0] = 16'h0011;
    v[1] = 16'h0022;
    v[2] = 16'h0033;
    acc = 0;
    for (int k = 0; k < 3; k++) begin
      bus.datain   = v[k];
      bus.signin   = 0;
      bus.in_valid = 1;
      if (bus.in_ready) acc++;
      @(negedge clk);
    end
    bus.in_valid = 0;
    chk("bp_acc", acc, 2);
    chk("bp_full", bus.in_ready, 0);
    repeat (3) begin
      chk("bp_stable", bus.dataout, 16'h0011);
      @(negedge clk);
    end
    bus.out_ready = 1;
    @(negedge clk);
    chk("bp_second", bus.dataout, 16'h0022);
    @(negedge clk);
    chk("bp_empty", bus.out_valid, 0);

    // 5 streaming
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("ready_comb", bus.in_ready,
          armed && q.size() < DEPTH);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.signin   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 6))
        0: bus.datain = 16'h0000;
        1: bus.datain = 16'h7FFF;
        2: bus.datain = 16'h8000;
        3: bus.datain = 16'h8001;
        4: bus.datain = 16'hFFFF;
        default: bus.datain = 16'($urandom);
      endcase
    end
    @(negedge clk);
    bus.in_valid  = 0;
    bus.out_ready = 1;
    repeat (4) @(negedge clk);

    // 6 counter ceiling
    sat_clr = 1;
    @(negedge clk);
    sat_clr = 0;
    chk("ceil_clr", sat_cnt, 0);
    n = 0;
    guard = 0;
    while (n < 260 && guard < 2000) begin
      bus.datain   = 16'hFFFF;
      bus.signin   = 0;
      bus.in_valid = 1;
      if (bus.in_ready) n++;
      @(negedge clk);
      guard++;
    end
    bus.in_valid = 0;
    chk("ceil_n", n, 260);
    chk("ceil_cnt", sat_cnt, 255);

    bus.out_ready = 0;
    bus.datain    = 16'd9;
    bus.in_valid  = 1;
    repeat (3) @(negedge clk);
    bus.in_valid = 0;
    chk("fill_full", bus.in_ready, 0);
    chk("fill_valid", bus.out_valid, 1);
    #2;
    rst_n = 0;
    #1;
    chk("mid_valid", bus.out_valid, 0);
    chk("mid_cnt", sat_cnt, 0);
    chk("mid_ready", bus.in_ready, 0);
    @(negedge clk);
    rst_n         = 1;
    bus.out_ready = 1;
    @(negedge clk);
    chk("mid_rel", bus.in_ready, 1);
    send(16'd7, 1, 16'hFFF9, 0, "post");
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
